// File: rtl/fir_interp2_polyphase.sv
// ============================================================================
// Module      : fir_interp2_polyphase
// Description : Rate-2 polyphase FIR interpolator. One shared MAC computes the
//               even phase (h[2k]) and then the odd phase (h[2k+1]) per input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_interp2_polyphase #(
    parameter int N  = 16,
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int OW = 32,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_phase,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data
);

    localparam int                c_HALF  = N / 2;
    localparam int                c_KW    = AW - 1;
    localparam logic [c_KW-1:0]   c_KLAST = c_KW'(c_HALF - 1);
    localparam logic [AW:0]       c_NLIM  = (AW + 1)'(N);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_MAC0 = 3'd1;
    localparam logic [2:0] c_OUT0 = 3'd2;
    localparam logic [2:0] c_MAC1 = 3'd3;
    localparam logic [2:0] c_OUT1 = 3'd4;

    logic [2:0]                r_state;
    logic [2:0]                w_next;
    logic signed [DW-1:0]      r_x [0:c_HALF-1];
    logic signed [CW-1:0]      r_h [0:N-1];
    logic signed [OW-1:0]      r_acc;
    logic [c_KW-1:0]           r_k;
    logic [OW-1:0]             r_out_data;
    logic                      r_out_phase;

    logic                      w_phase;
    logic [AW-1:0]             w_hidx;
    logic signed [DW+CW-1:0]   w_prod;
    logic signed [OW-1:0]      w_sum;

    // Coefficient index 2k+phase is simply {k, phase}
    assign w_phase = (r_state == c_MAC1);
    assign w_hidx  = {r_k, w_phase};
    assign w_prod  = r_x[r_k] * r_h[w_hidx];
    assign w_sum   = r_acc + OW'(w_prod);

    assign out_data  = r_out_data;
    assign out_phase = r_out_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)       w_next = c_MAC0;
            c_MAC0:  if (r_k == c_KLAST) w_next = c_OUT0;
            c_OUT0:  if (out_ready)      w_next = c_MAC1;
            c_MAC1:  if (r_k == c_KLAST) w_next = c_OUT1;
            c_OUT1:  if (out_ready)      w_next = c_IDLE;
            default:                     w_next = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_OUT0) || (r_state == c_OUT1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_k         <= '0;
            r_out_data  <= '0;
            r_out_phase <= 1'b0;
            for (int i = 0; i < c_HALF; i++) r_x[i] <= '0;
            for (int i = 0; i < N; i++)      r_h[i] <= '0;
        end else begin
            // Writes land only while no computation is in flight
            if ((r_state == c_IDLE) && coef_we && ({1'b0, coef_addr} < c_NLIM)) begin
                r_h[coef_addr] <= coef_data;
            end
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        for (int i = c_HALF - 1; i > 0; i--) r_x[i] <= r_x[i-1];
                        r_x[0] <= in_data;
                        r_acc  <= '0;
                        r_k    <= '0;
                    end
                end
                c_MAC0, c_MAC1: begin
                    r_acc <= w_sum;
                    r_k   <= r_k + c_KW'(1);
                    if (r_k == c_KLAST) begin
                        r_out_data  <= w_sum;
                        r_out_phase <= w_phase;
                        r_k         <= '0;
                    end
                end
                c_OUT0: begin
                    if (out_ready) begin
                        r_acc <= '0;
                        r_k   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_interp2_polyphase.sv
// ============================================================================
// Module      : tb_fir_interp2_polyphase
// Description : Scoreboard bench with a sum-of-products reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_interp2_polyphase;

    localparam int N    = 16;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int OW   = 32;
    localparam int AW   = 4;
    localparam int HALF = N / 2;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data   = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_phase;
    logic          coef_we   = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [CW-1:0] coef_data = '0;

    fir_interp2_polyphase #(.N(N), .DW(DW), .CW(CW), .OW(OW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_phase (out_phase),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [OW-1:0] d;
        logic          p;
    } exp_t;

    exp_t exp_q[$];
    int   mh [N];
    int   mx [HALF];
    int   checks    = 0;
    int   failures  = 0;
    int   rdy_mode  = 0;
    bit   thru_chk  = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: newest sample at x[0]; phase p output = sum_k x[k]*h[2k+p] mod 2^OW
    function automatic void model_accept(input int d);
        exp_t e;
        longint s;
        for (int i = HALF - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = d;
        for (int p = 0; p < 2; p++) begin
            s = 0;
            for (int k = 0; k < HALF; k++) s += longint'(mx[k]) * longint'(mh[2*k+p]);
            e.d = OW'(s);
            e.p = p[0];
            exp_q.push_back(e);
        end
    endfunction

    task automatic send(input logic [DW-1:0] d, input bit we = 1'b0,
                        input int a = 0, input logic [CW-1:0] cd = '0);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=%0d required 1", in_ready);
        end else begin
            if (we) begin
                coef_we   = 1'b1;
                coef_addr = AW'(a);
                coef_data = cd;
                mh[a]     = int'($signed(cd));
            end
            model_accept(int'($signed(d)));
        end
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic wr_coef(input int a, input logic [CW-1:0] v, input bit take);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = v;
        @(negedge clk);
        coef_we = 1'b0;
        if (take) mh[a] = int'($signed(v));
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || !in_ready) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic wait_out0();
        int t = 0;
        while (!(out_valid && !out_phase) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("wait_out0_valid", out_valid, 1);
    endtask

    // Monitor: drives out_ready, pops the scoreboard on each handshake, checks timing
    logic          m_pv     = 1'b0;
    logic          m_pstall = 1'b0;
    logic [OW-1:0] m_pd     = '0;
    logic          m_pp     = 1'b0;
    int            m_last_evt = -1;
    int            m_last_acc = -1;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
            #4;
            chk("ready_valid_exclusive", out_valid && in_ready, 0);
            if (out_valid && m_pstall) begin
                chk("hold_data", out_data, m_pd);
                chk("hold_phase", out_phase, m_pp);
            end
            if (out_valid && !m_pv && m_last_evt >= 0)
                chk("valid_latency", cyc + 1 - m_last_evt, HALF + 1);
            if (!thru_chk) m_last_acc = -1;
            if (in_valid && in_ready) begin
                if (thru_chk && m_last_acc >= 0)
                    chk("accept_spacing", cyc + 1 - m_last_acc, N + 3);
                m_last_acc = cyc + 1;
                m_last_evt = cyc + 1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got data=%0h, none expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_phase", out_phase, e.p);
                end
                if (!out_phase) m_last_evt = cyc + 1;
            end
            m_pstall = out_valid && !out_ready;
            m_pd     = out_data;
            m_pp     = out_phase;
            m_pv     = out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [OW-1:0] held;
        for (int i = 0; i < N; i++) mh[i] = 0;
        for (int i = 0; i < HALF; i++) mx[i] = 0;

        #1 rst = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_phase", out_phase, 0);
        @(negedge clk);
        rst = 1'b0;

        // Impulse response: outputs 1..16 then zeros
        rdy_mode = 0;
        for (int i = 0; i < N; i++) wr_coef(i, CW'(i + 1), 1'b1);
        send(16'd1);
        for (int i = 0; i < 9; i++) send(16'd0);
        drain();

        // Write guard: write during MAC1 ignored, write in IDLE applied
        send(16'd1);
        wait_out0();
        @(negedge clk);
        wr_coef(0, 16'h7FFF, 1'b0);
        drain();
        send(16'd1);
        drain();
        wr_coef(0, 16'h7FFF, 1'b1);
        send(16'd1);
        drain();

        // Coefficient write coincident with input acceptance
        send(16'd5, 1'b1, 2, 16'hFFF9);
        drain();

        // Latency and throughput with in_valid and out_ready held high
        thru_chk = 1'b1;
        for (int i = 0; i < 4; i++) send(16'($urandom));
        drain();
        thru_chk = 1'b0;

        // Backpressure in OUT0; a pending input must not be consumed
        rdy_mode = 2;
        send(16'h0123);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        wait_out0();
        held = out_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, held);
            chk("bp_out_phase", out_phase, 0);
        end
        rdy_mode = 0;
        send(16'hBEEF);
        drain();

        // Randomized coefficients, samples, gaps and backpressure
        rdy_mode = 1;
        for (int i = 0; i < N; i++) wr_coef(i, CW'($urandom), 1'b1);
        for (int i = 0; i < 24; i++) begin
            if (i == 10) send(16'($urandom), 1'b1, $urandom_range(0, N - 1), 16'($urandom));
            else         send(16'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat ($urandom_range(0, 5)) @(negedge clk);
            end
        end
        drain();

        // Asynchronous reset mid-MAC0
        rdy_mode = 0;
        send(16'h1234);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("areset_in_ready", in_ready, 1);
        chk("areset_out_valid", out_valid, 0);
        chk("areset_out_data", out_data, 0);
        chk("areset_out_phase", out_phase, 0);
        exp_q.delete();
        for (int i = 0; i < N; i++) mh[i] = 0;
        for (int i = 0; i < HALF; i++) mx[i] = 0;
        #1 rst = 1'b0;
        send(16'd1);
        send(16'd0);
        drain();

        // Wraparound: 8 x (-2^15 * -2^15) = 2^33 wraps to 0
        for (int i = 0; i < N; i++) wr_coef(i, 16'h8000, 1'b1);
        for (int i = 0; i < 8; i++) send(16'h8000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir_interp2_polyphase.md
# fir_interp2_polyphase

Rate-2 polyphase FIR interpolator: each accepted input sample produces two output samples, phase 0 and then phase 1. Each phase is computed by one time-multiplexed multiply-accumulate unit. The block sits after the L=2 parallel FIR datapath in the filter chain and converts back up to the doubled sample rate. Coefficients are loaded at runtime through a write port; input and output use valid/ready streams.

## Interface
- N, 16, total taps; must be even and ≥ 4. Each phase has N/2 taps.
- DW, 16, input sample width (signed).
- CW, 16, coefficient width (signed).
- OW, 32, accumulator and output width (signed); must be ≥ DW+CW.
- AW, $clog2(N), coefficient address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DW  signed input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  OW  signed output sample.
- out_phase  out  1  0 = even-phase output, 1 = odd-phase output.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  AW  coefficient index 0..N-1.
- coef_data  in  CW  signed coefficient value.

## Operation
- Storage:
  - Coefficient RAM h[0..N-1].
  - Delay line x[0..N/2-1], where x[0] is the newest sample.
  - Accumulator acc (OW bits).
  - Tap counter k (0..N/2-1).
- FSM states: IDLE, MAC0, OUT0, MAC1, OUT1.
- IDLE:
  - in_ready=1.
  - On in_valid: shift x[i] ← x[i-1] and x[0] ← in_data, clear acc and k, then go to MAC0.
- MAC0: each cycle acc ← acc + x[k]*h[2k] and k ← k+1. After k=N/2-1, load the result into out_data, set out_phase=0, go to OUT0.
- OUT0: out_valid=1. out_data and out_phase stay stable until out_ready. On the handshake, clear acc and k and go to MAC1.
- MAC1: same as MAC0 but uses h[2k+1]. Ends in OUT1 with out_phase=1.
- OUT1: on the handshake, go to IDLE.
- Arithmetic:
  - Each product is a full-precision signed (DW+CW)-bit value, sign-extended to OW.
  - The accumulator wraps modulo 2^OW. There is no saturation and no rounding.
  - out_data is the raw accumulator.
- Coefficient writes:
  - Accepted only in IDLE; h[coef_addr] ← coef_data at the edge.
  - coef_we in any other state is ignored and the RAM is unchanged.
  - If a write and an input acceptance happen in the same IDLE cycle, both occur. The new coefficient is used by the computation just started.
  - coef_addr ≥ N is ignored.
- in_valid while in_ready=0 is not consumed. The sample is taken when the FSM returns to IDLE.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, out_phase=0.
  - FSM in IDLE, acc=0, k=0.
  - All x[] = 0 and all h[] = 0.
- Reset mid-operation aborts the computation immediately (asynchronous). No partial output is presented and the delay line is cleared.
- Input accepted at edge E: in_ready falls after E, and the phase-0 out_valid rises at edge E+N/2+1.
- Phase-0 handshake at edge F: out_valid falls after F, and the phase-1 out_valid rises at edge F+N/2+1.
- Phase-1 handshake at edge G: in_ready rises after G.
- Throughput with out_ready held at 1: one input every N+3 cycles, giving two outputs per input.
- out_valid is never asserted in the same cycle as in_ready.

## Test plan
- Impulse response (N=16):
  - Load h[i]=i+1, then feed 1 followed by seven 0s with out_ready=1.
  - Outputs must be 1,2,3,…,16 with out_phase alternating 0,1.
  - Further 0 inputs must give 0.
- Latency and throughput:
  - Hold in_valid=1 and out_ready=1.
  - out_valid must rise exactly N/2+1 cycles after each acceptance and after each phase-0 handshake.
  - Acceptances must be spaced N+3 cycles apart.
- Backpressure:
  - Hold out_ready=0 for 20 cycles in OUT0.
  - out_data and out_phase must stay stable, in_ready=0, and no input is consumed.
  - Results must be unchanged after out_ready is released.
- Write guard:
  - Write h[0]=0x7FFF during MAC1; h[0] must be unchanged (readback via the next impulse output).
  - The same write in IDLE must take effect.
- Wraparound:
  - Set all h=0x8000 and feed eight inputs of 0x8000 (OW=32).
  - Phase-0 result must be 8×2^30 mod 2^32 = 0 with no saturation.
- Asynchronous reset:
  - Assert rst mid-MAC0 for less than one cycle.
  - All outputs must return to reset values immediately.
  - The next impulse must give 0s, since coefficients are cleared.
